// File: rtl/axil_mp_ram.sv
// Multi-port AXI4-Lite RAM: several slave ports share one single-access-per-cycle
// word array; a round-robin arbiter hands the array to one port per clock.
module axil_mp_ram #(
   parameter int PORTS           = 2,
   parameter int DATA_WIDTH      = 32,
   parameter int ADDR_WIDTH      = 16,
   parameter int STRB_WIDTH      = DATA_WIDTH / 8,
   parameter int DEPTH           = 1024,
   parameter int PIPELINE_OUTPUT = 0
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [PORTS*ADDR_WIDTH-1:0]      s_axil_awaddr,
   input  logic [PORTS*3-1:0]               s_axil_awprot,
   input  logic [PORTS-1:0]                 s_axil_awvalid,
   output logic [PORTS-1:0]                 s_axil_awready,
   input  logic [PORTS*DATA_WIDTH-1:0]      s_axil_wdata,
   input  logic [PORTS*STRB_WIDTH-1:0]      s_axil_wstrb,
   input  logic [PORTS-1:0]                 s_axil_wvalid,
   output logic [PORTS-1:0]                 s_axil_wready,
   output logic [PORTS*2-1:0]               s_axil_bresp,
   output logic [PORTS-1:0]                 s_axil_bvalid,
   input  logic [PORTS-1:0]                 s_axil_bready,
   input  logic [PORTS*ADDR_WIDTH-1:0]      s_axil_araddr,
   input  logic [PORTS*3-1:0]               s_axil_arprot,
   input  logic [PORTS-1:0]                 s_axil_arvalid,
   output logic [PORTS-1:0]                 s_axil_arready,
   output logic [PORTS*DATA_WIDTH-1:0]      s_axil_rdata,
   output logic [PORTS*2-1:0]               s_axil_rresp,
   output logic [PORTS-1:0]                 s_axil_rvalid,
   input  logic [PORTS-1:0]                 s_axil_rready
);

   localparam int PW    = (PORTS > 1) ? $clog2(PORTS) : 1;
   localparam int SHIFT = $clog2(STRB_WIDTH);
   localparam int MW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [PW-1:0]       LAST_PORT = PW'(PORTS - 1);
   localparam logic                PIPE      = (PIPELINE_OUTPUT != 0);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [PORTS-1:0]            wr_elig, rd_elig, do_write, req, gnt_vec;
   logic [PORTS-1:0]            last_read, pipe_valid;
   logic [PORTS*DATA_WIDTH-1:0] pipe_data;
   logic [PORTS*2-1:0]          pipe_resp;

   logic [PW-1:0]         rr_ptr, gnt_idx;
   logic                  gnt_valid, g_write, g_in_range;
   logic [ADDR_WIDTH-1:0] g_addr, g_word;
   logic [DATA_WIDTH-1:0] g_wdata, g_rdata;
   logic [STRB_WIDTH-1:0] g_wstrb;
   logic [1:0]            g_resp;

   // Handshakes: a channel transfers on the rising edge where valid and ready are both
   // high; the RAM raises awready/wready/arready for one cycle only after it has already
   // performed the access, and holds bvalid/rvalid with stable payload until taken.
   always_comb begin
      wr_elig  = '0;
      rd_elig  = '0;
      do_write = '0;
      req      = '0;
      for (int p = 0; p < PORTS; p++) begin
         wr_elig[p]  = s_axil_awvalid[p] & s_axil_wvalid[p] & ~s_axil_awready[p]
                     & ~s_axil_wready[p] & (~s_axil_bvalid[p] | s_axil_bready[p]);
         rd_elig[p]  = s_axil_arvalid[p] & ~s_axil_arready[p]
                     & (~s_axil_rvalid[p] | s_axil_rready[p] | (PIPE & ~pipe_valid[p]));
         // last_read breaks the tie so a port issuing both kinds alternates them
         do_write[p] = wr_elig[p] & (~rd_elig[p] | last_read[p]);
         req[p]      = wr_elig[p] | rd_elig[p];
      end
   end

   always_comb begin
      int c;
      c         = 0;
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      for (int i = 0; i < PORTS; i++) begin
         c = int'(rr_ptr) + i;
         if (c >= PORTS) c = c - PORTS;
         if (!gnt_valid && req[c]) begin
            gnt_valid = 1'b1;
            gnt_idx   = PW'(c);
         end
      end
   end

   always_comb begin
      gnt_vec = '0;
      g_write = 1'b0;
      g_addr  = '0;
      g_wdata = '0;
      g_wstrb = '0;
      for (int p = 0; p < PORTS; p++) begin
         gnt_vec[p] = gnt_valid && (gnt_idx == PW'(p));
         if (gnt_idx == PW'(p)) begin
            g_write = do_write[p];
            g_addr  = do_write[p] ? s_axil_awaddr[p*ADDR_WIDTH +: ADDR_WIDTH]
                                  : s_axil_araddr[p*ADDR_WIDTH +: ADDR_WIDTH];
            g_wdata = s_axil_wdata[p*DATA_WIDTH +: DATA_WIDTH];
            g_wstrb = s_axil_wstrb[p*STRB_WIDTH +: STRB_WIDTH];
         end
      end
      g_word     = g_addr >> SHIFT;
      g_in_range = ({1'b0, g_word} < DEPTH_LIM);
      g_resp     = g_in_range ? 2'b00 : 2'b10;
      g_rdata    = g_in_range ? mem[g_word[MW-1:0]] : '0;
   end

   // Array has no reset; a granted in-range write lands on the grant edge.
   always_ff @(posedge clk) begin
      if (rst_n && gnt_valid && g_write && g_in_range) begin
         for (int b = 0; b < STRB_WIDTH; b++) begin
            if (g_wstrb[b]) mem[g_word[MW-1:0]][b*8 +: 8] <= g_wdata[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr         <= '0;
         last_read      <= '0;
         pipe_valid     <= '0;
         pipe_data      <= '0;
         pipe_resp      <= '0;
         s_axil_awready <= '0;
         s_axil_wready  <= '0;
         s_axil_bresp   <= '0;
         s_axil_bvalid  <= '0;
         s_axil_arready <= '0;
         s_axil_rdata   <= '0;
         s_axil_rresp   <= '0;
         s_axil_rvalid  <= '0;
      end else begin
         if (gnt_valid) rr_ptr <= (gnt_idx == LAST_PORT) ? '0 : gnt_idx + 1'b1;
         for (int p = 0; p < PORTS; p++) begin
            s_axil_awready[p] <= 1'b0;
            s_axil_wready[p]  <= 1'b0;
            s_axil_arready[p] <= 1'b0;
            if (s_axil_bvalid[p] && s_axil_bready[p]) s_axil_bvalid[p] <= 1'b0;
            if (PIPE) begin
               // the extra stage drains into the output whenever the output is free
               if (!s_axil_rvalid[p] || s_axil_rready[p]) begin
                  s_axil_rvalid[p] <= pipe_valid[p];
                  pipe_valid[p]    <= 1'b0;
                  if (pipe_valid[p]) begin
                     s_axil_rdata[p*DATA_WIDTH +: DATA_WIDTH] <= pipe_data[p*DATA_WIDTH +: DATA_WIDTH];
                     s_axil_rresp[p*2 +: 2]                   <= pipe_resp[p*2 +: 2];
                  end
               end
            end else if (s_axil_rvalid[p] && s_axil_rready[p]) begin
               s_axil_rvalid[p] <= 1'b0;
            end
            if (gnt_vec[p]) begin
               if (g_write) begin
                  s_axil_awready[p]      <= 1'b1;
                  s_axil_wready[p]       <= 1'b1;
                  s_axil_bvalid[p]       <= 1'b1;
                  s_axil_bresp[p*2 +: 2] <= g_resp;
                  last_read[p]           <= 1'b0;
               end else begin
                  s_axil_arready[p] <= 1'b1;
                  last_read[p]      <= 1'b1;
                  if (PIPE) begin
                     pipe_valid[p]                         <= 1'b1;
                     pipe_data[p*DATA_WIDTH +: DATA_WIDTH] <= g_rdata;
                     pipe_resp[p*2 +: 2]                   <= g_resp;
                  end else begin
                     s_axil_rvalid[p]                         <= 1'b1;
                     s_axil_rdata[p*DATA_WIDTH +: DATA_WIDTH] <= g_rdata;
                     s_axil_rresp[p*2 +: 2]                   <= g_resp;
                  end
               end
            end
         end
      end
   end

endmodule
